vote_console_tx: RTL and testbench
==================================

Name: vote_console_tx

Overview:
- Ballot-terminal front end that drives the voting machine's input pin bus (voter one-hot, confirm, mode) from raw front-panel buttons.
- Debounces the buttons, latches a single candidate selection, and issues a timed confirm strobe with setup and hold margins around it.
- Sequences the machine between voting (00), counting (01) and wipe (10) modes.
- Sits on the initiator side of the interface; its outputs connect directly to the machine's ui_in[7:0].

Parameters:
- DEB_CYC, 4: consecutive stable synchronised samples needed before a debounced level changes.
- SETUP_CYC, 2: cycles voter is driven with confirm low before the strobe.
- PULSE_CYC, 2: cycles confirm is high; also the length of the wipe pulse.
- HOLD_CYC, 2: cycles voter is held after confirm falls.
- MAX_VOTES, 255: vote limit, used only under VOTE_LIMIT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- btn  in  4  raw candidate buttons, asynchronous; btn[i] selects candidate i
- cast_btn  in  1  raw cast button, asynchronous
- close_btn  in  1  raw close/reopen button, asynchronous
- voter  out  4  one-hot candidate to the machine
- confirm  out  1  vote strobe to the machine
- mode  out  2  00 voting, 01 counting, 10 wipe
- busy  out  1  high while a transaction is in flight
- closed  out  1  high in CLOSED state
- err  out  1  one-cycle pulse on a rejected press
- vote_cnt  out  8  votes sent since reset or wipe; saturates at 255

Behaviour:
- Reset values: voter=0, confirm=0, mode=00, busy=0, closed=0, err=0, vote_cnt=0, sel=0, state=IDLE, all debouncers low.
- Reset mid-transaction aborts immediately. confirm drops asynchronously and no vote is counted.
- Input conditioning:
  - Each of the 6 raw inputs passes through a 2-flop synchroniser, then a per-input stable counter.
  - The debounced level takes the synchronised value once that value has differed from the current debounced level for DEB_CYC consecutive cycles.
  - A raw level held from cycle t changes the debounced level at t+2+DEB_CYC.
  - A press is the debounced rising edge: a 1-cycle event.
- Selection register sel[3:0], updated only in IDLE:
  - Press on btn[i] while exactly one debounced btn is high: sel <= 1<<i. Reselecting overwrites.
  - Press while two or more debounced btn are high: sel <= 0 and err pulses.
- States:
  - IDLE: mode=00, voter=0, confirm=0.
    - cast press with sel!=0 goes to SETUP.
    - cast press with sel==0 pulses err and stays in IDLE.
    - close press goes to CLOSED.
    - cast and close in the same cycle: close wins, cast is ignored.
  - SETUP: voter=sel, confirm=0 for SETUP_CYC cycles, then STROBE.
  - STROBE: voter=sel, confirm=1 for PULSE_CYC cycles, then HOLD.
  - HOLD: voter=sel, confirm=0 for HOLD_CYC cycles.
    - On exit: vote_cnt+1 (saturating at 255), sel<=0, next state IDLE, voter=0 on the following cycle.
  - CLOSED: mode=01, closed=1.
    - close press goes to IDLE (mode=00).
    - cast press goes to WIPE.
    - btn presses are ignored.
  - WIPE: mode=10 for PULSE_CYC cycles, vote_cnt<=0, sel<=0, then IDLE.
- busy=1 in SETUP, STROBE, HOLD and WIPE. All presses during busy are ignored, with no err pulse.
- Every output is registered; no combinational path from any input to an output.
- Per-vote timing: from the first SETUP cycle, confirm rises after SETUP_CYC cycles, is high for PULSE_CYC cycles, and busy falls after SETUP_CYC+PULSE_CYC+HOLD_CYC cycles (6 at defaults).

Optional Feature:
- Macro: VOTE_LIMIT_EN.
- Defined: a cast press in IDLE when vote_cnt >= MAX_VOTES pulses err and stays in IDLE; no transaction starts.
- Undefined: casting is unlimited and vote_cnt saturates at 255 while transactions continue.

Test Plan:
- Reset, then hold btn[2] high for 10 cycles and pulse cast_btn (held 10 cycles).
  - Expect voter=0100 for exactly 6 cycles.
  - Expect confirm high on cycles 3-4 of that window.
  - Expect vote_cnt=1, sel=0, busy=0 afterwards.
- btn[0] chatter: 1-cycle glitches every other cycle for 12 cycles, then released.
  - No selection; a following cast press pulses err; vote_cnt stays 0.
- btn[1] and btn[3] held high together, then press:
  - sel=0 and err pulses; a following cast pulses err and gives no strobe.
- Three select/cast votes (btn 0, 0, 3), then close press:
  - mode=01, closed=1, vote_cnt=3.
  - Then cast press: mode=10 for 2 cycles, vote_cnt=0, state IDLE with mode=00.
- Start a vote, assert rst during STROBE:
  - confirm=0, voter=0, mode=00 immediately; vote_cnt unchanged at 0.
  - After release, a new vote works normally.
- With VOTE_LIMIT_EN and MAX_VOTES=2: cast 3 valid votes.
  - Third press pulses err; confirm is seen exactly twice; vote_cnt=2.

Source files
------------

// File: rtl/vote_console_tx.sv
// Ballot-terminal front end: debounces the panel buttons and drives voter/confirm/mode to the machine.
// Optional vote limit is enabled by defining VOTE_LIMIT_EN.
module vote_console_tx #(
   parameter int DEB_CYC   = 4,
   parameter int SETUP_CYC = 2,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 2,
   parameter int MAX_VOTES = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] btn,
   input  logic       cast_btn,
   input  logic       close_btn,
   output logic [3:0] voter,
   output logic       confirm,
   output logic [1:0] mode,
   output logic       busy,
   output logic       closed,
   output logic       err,
   output logic [7:0] vote_cnt
);

   localparam int CW   = $clog2(DEB_CYC + 1);
   localparam int T1   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int TMAX = (T1 > HOLD_CYC) ? T1 : HOLD_CYC;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [7:0] VOTE_MAX = 8'(MAX_VOTES);
`ifdef VOTE_LIMIT_EN
   localparam bit LIMIT_ON = 1'b1;
`else
   localparam bit LIMIT_ON = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, CLOSED, WIPE} state_t;

   state_t              state;
   logic [5:0]          raw, s1, s2, deb, deb_q, press;
   logic [5:0][CW-1:0]  dcnt;
   logic [3:0]          sel;
   logic [TW-1:0]       tcnt;
   logic [3:0]          bpress;
   logic                cast_p, close_p, limit_hit;

   assign raw       = {close_btn, cast_btn, btn};
   assign press     = deb & ~deb_q;
   assign bpress    = press[3:0];
   assign cast_p    = press[4];
   assign close_p   = press[5];
   assign limit_hit = LIMIT_ON && (vote_cnt >= VOTE_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // Debounced level follows s2 only after DEB_CYC consecutive differing samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dcnt  <= '0;
         deb   <= '0;
         deb_q <= '0;
      end else begin
         deb_q <= deb;
         for (int g = 0; g < 6; g++) begin
            if (s2[g] == deb[g]) begin
               dcnt[g] <= '0;
            end else if (dcnt[g] == CW'(DEB_CYC - 1)) begin
               deb[g]  <= s2[g];
               dcnt[g] <= '0;
            end else begin
               dcnt[g] <= dcnt[g] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         sel      <= '0;
         tcnt     <= '0;
         voter    <= '0;
         confirm  <= 1'b0;
         mode     <= 2'b00;
         busy     <= 1'b0;
         closed   <= 1'b0;
         err      <= 1'b0;
         vote_cnt <= '0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (close_p) begin
                  state  <= CLOSED;
                  mode   <= 2'b01;
                  closed <= 1'b1;
               end else if (cast_p) begin
                  if (sel == 4'd0 || limit_hit) begin
                     err <= 1'b1;
                  end else begin
                     state <= SETUP;
                     voter <= sel;
                     busy  <= 1'b1;
                     tcnt  <= '0;
                  end
               end else if (|bpress) begin
                  // A press only counts as a selection when it is the sole button held.
                  if ($onehot(deb[3:0])) begin
                     sel <= deb[3:0];
                  end else begin
                     sel <= '0;
                     err <= 1'b1;
                  end
               end
            end
            SETUP: begin
               if (tcnt == TW'(SETUP_CYC - 1)) begin
                  state   <= STROBE;
                  confirm <= 1'b1;
                  tcnt    <= '0;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            STROBE: begin
               if (tcnt == TW'(PULSE_CYC - 1)) begin
                  state   <= HOLD;
                  confirm <= 1'b0;
                  tcnt    <= '0;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            HOLD: begin
               if (tcnt == TW'(HOLD_CYC - 1)) begin
                  state <= IDLE;
                  voter <= '0;
                  busy  <= 1'b0;
                  sel   <= '0;
                  tcnt  <= '0;
                  if (vote_cnt != 8'hFF) vote_cnt <= vote_cnt + 8'd1;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            CLOSED: begin
               if (close_p) begin
                  state  <= IDLE;
                  mode   <= 2'b00;
                  closed <= 1'b0;
               end else if (cast_p) begin
                  state    <= WIPE;
                  mode     <= 2'b10;
                  closed   <= 1'b0;
                  busy     <= 1'b1;
                  vote_cnt <= '0;
                  sel      <= '0;
                  tcnt     <= '0;
               end
            end
            WIPE: begin
               if (tcnt == TW'(PULSE_CYC - 1)) begin
                  state <= IDLE;
                  mode  <= 2'b00;
                  busy  <= 1'b0;
                  tcnt  <= '0;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vote_console_tx.sv
// Self-checking bench for vote_console_tx: directed scenarios plus random press sequences
// checked against a press-level model of selection, voting, closing and wiping.
module tb_vote_console_tx;

`ifdef VOTE_LIMIT_EN
   localparam bit LIM  = 1'b1;
   localparam int MAXV = 2;
`else
   localparam bit LIM  = 1'b0;
   localparam int MAXV = 255;
`endif
   localparam int PULSE = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] btn = '0;
   logic       cast_btn = 1'b0;
   logic       close_btn = 1'b0;
   logic [3:0] voter;
   logic       confirm;
   logic [1:0] mode;
   logic       busy, closed, err;
   logic [7:0] vote_cnt;

   vote_console_tx #(.MAX_VOTES(MAXV)) dut (
      .clk(clk), .rst(rst), .btn(btn), .cast_btn(cast_btn), .close_btn(close_btn),
      .voter(voter), .confirm(confirm), .mode(mode), .busy(busy), .closed(closed),
      .err(err), .vote_cnt(vote_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int n_err = 0, n_conf = 0, n_wipe = 0;
   logic [3:0] conf_voter = '0;
   logic       conf_q = 1'b0;

   // Model state: what the console should hold after each completed press.
   int         m_cnt = 0;
   logic [3:0] m_sel = '0;
   bit         m_closed = 1'b0;

   always @(negedge clk) begin
      if (err) n_err <= n_err + 1;
      if (confirm && !conf_q) begin
         n_conf     <= n_conf + 1;
         conf_voter <= voter;
      end
      conf_q <= confirm;
      if (mode == 2'b10) n_wipe <= n_wipe + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1; btn = '0; cast_btn = 1'b0; close_btn = 1'b0;
      cyc(4);
      rst = 1'b0;
      cyc(2);
      m_cnt = 0; m_sel = '0; m_closed = 1'b0;
   endtask

   // kind: 0 single button i, 1 buttons i and j together, 2 cast, 3 close
   task automatic do_action(input int kind, input int i, input int j, input string tag);
      int e0, c0, w0, ee, ec, ew;
      logic [3:0] ev, braw;
      e0 = n_err; c0 = n_conf; w0 = n_wipe;
      ee = 0; ec = 0; ew = 0; ev = '0; braw = '0;
      case (kind)
         0: begin
            braw[i] = 1'b1;
            if (!m_closed) m_sel = 4'b0001 << i;
         end
         1: begin
            braw[i] = 1'b1; braw[j] = 1'b1;
            if (!m_closed) begin m_sel = '0; ee = 1; end
         end
         2: begin
            if (m_closed) begin
               ew = PULSE; m_cnt = 0; m_sel = '0; m_closed = 1'b0;
            end else if (m_sel == 4'd0 || (LIM && m_cnt >= MAXV)) begin
               ee = 1;
            end else begin
               ec = 1; ev = m_sel; m_sel = '0;
               m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
            end
         end
         default: m_closed = !m_closed;
      endcase
      btn = braw; cast_btn = (kind == 2); close_btn = (kind == 3);
      cyc(9);
      btn = '0; cast_btn = 1'b0; close_btn = 1'b0;
      cyc(10);
      chk({tag, "_err"}, n_err - e0, ee);
      chk({tag, "_strobes"}, n_conf - c0, ec);
      if (ec == 1) chk({tag, "_voter"}, conf_voter, ev);
      chk({tag, "_wipe_cyc"}, n_wipe - w0, ew);
      chk({tag, "_vote_cnt"}, vote_cnt, m_cnt);
      chk({tag, "_mode"}, mode, m_closed ? 2'b01 : 2'b00);
      chk({tag, "_closed"}, closed, m_closed);
      chk({tag, "_busy"}, busy, 1'b0);
   endtask

   initial begin
      int found;
      logic [6:0] vpat, cpat, bpat;
      int kind, a, b;

      // Reset state
      cyc(3);
      chk("rst_voter", voter, 4'd0);
      chk("rst_confirm", confirm, 1'b0);
      chk("rst_mode", mode, 2'b00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_closed", closed, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_cnt", vote_cnt, 8'd0);
      rst = 1'b0;
      cyc(2);

      // Single vote with cycle-level timing of the strobe window
      do_action(0, 2, 0, "t1_sel");
      cast_btn = 1'b1;
      found = 0;
      for (int k = 0; k < 30 && found == 0; k++) begin
         if (voter != 4'd0) found = 1;
         else cyc(1);
      end
      chk("t1_start", found, 1);
      for (int k = 0; k < 7; k++) begin
         vpat[k] = (voter == 4'b0100);
         cpat[k] = confirm;
         bpat[k] = busy;
         cyc(1);
      end
      cast_btn = 1'b0;
      cyc(12);
      m_cnt = 1; m_sel = '0;
      chk("t1_voter_pat", vpat, 7'b0111111);
      chk("t1_confirm_pat", cpat, 7'b0001100);
      chk("t1_busy_pat", bpat, 7'b0111111);
      chk("t1_cnt", vote_cnt, 8'd1);
      do_action(2, 0, 0, "t1_sel_cleared");

      // Chatter on btn[0] never debounces into a selection
      for (int k = 0; k < 12; k++) begin
         btn = (k % 2 == 0) ? 4'b0001 : 4'b0000;
         cyc(1);
      end
      btn = '0;
      cyc(12);
      do_action(2, 0, 0, "chatter_cast");

      // Two buttons at once
      do_action(1, 1, 3, "dual_sel");
      do_action(2, 0, 0, "dual_cast");

      // Three votes, close, wipe
      apply_reset();
      do_action(0, 0, 0, "v1_sel");
      do_action(2, 0, 0, "v1_cast");
      do_action(0, 0, 0, "v2_sel");
      do_action(2, 0, 0, "v2_cast");
      do_action(0, 3, 0, "v3_sel");
      do_action(2, 0, 0, "v3_cast");
      do_action(3, 0, 0, "close");
`ifndef VOTE_LIMIT_EN
      chk("close_cnt3", vote_cnt, 8'd3);
`endif
      do_action(0, 1, 0, "closed_btn_ignored");
      do_action(2, 0, 0, "wipe");

      // Reset in the middle of the strobe
      do_action(0, 1, 0, "rs_sel");
      cast_btn = 1'b1;
      found = 0;
      for (int k = 0; k < 30 && found == 0; k++) begin
         if (confirm) found = 1;
         else cyc(1);
      end
      chk("rs_strobe_seen", found, 1);
      #2 rst = 1'b1;
      #1;
      chk("rs_confirm", confirm, 1'b0);
      chk("rs_voter", voter, 4'd0);
      chk("rs_mode", mode, 2'b00);
      chk("rs_busy", busy, 1'b0);
      chk("rs_cnt", vote_cnt, 8'd0);
      cast_btn = 1'b0;
      cyc(3);
      rst = 1'b0;
      cyc(3);
      m_cnt = 0; m_sel = '0; m_closed = 1'b0;
      do_action(0, 2, 0, "rs_after_sel");
      do_action(2, 0, 0, "rs_after_cast");

      // Random press sequences against the model
      for (int r = 0; r < 30; r++) begin
         kind = $urandom_range(0, 5);
         a = $urandom_range(0, 3);
         b = (a + 1 + $urandom_range(0, 2)) % 4;
         case (kind)
            0, 1:    do_action(0, a, 0, "rnd_sel");
            2:       do_action(1, a, b, "rnd_dual");
            3, 4:    do_action(2, 0, 0, "rnd_cast");
            default: do_action(3, 0, 0, "rnd_close");
         endcase
      end

      apply_reset();
`ifdef VOTE_LIMIT_EN
      begin
         int c0;
         c0 = n_conf;
         for (int v = 0; v < 3; v++) begin
            do_action(0, v, 0, "lim_sel");
            do_action(2, 0, 0, "lim_cast");
         end
         chk("lim_strobes", n_conf - c0, 2);
         chk("lim_cnt", vote_cnt, 8'd2);
      end
`else
      for (int v = 0; v < 256; v++) begin
         do_action(0, v % 4, 0, "sat_sel");
         do_action(2, 0, 0, "sat_cast");
      end
      chk("sat_cnt", vote_cnt, 8'd255);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
